mult_pipe: RTL
==============

// Module: mult_pipe
// PURPOSE
//  Pipelined, parameterised integer multiplier: WIDTH x WIDTH -> 2*WIDTH product.
//  Partial products are summed over STAGES register stages, WIDTH/STAGES rows per stage.
//  Valid/ready on both sides; accepts one operand pair per cycle when not stalled.
//  Used by the feature-evaluation datapath: rectangle weight x integral-image sum,
//  and variance normalisation.
// PARAMETERS
//  WIDTH   32  operand width in bits; must be >= 2
//  STAGES  4   pipeline depth in cycles; must divide WIDTH exactly (elaboration $error otherwise)
// PORTS
//  clock        in   1              rising-edge clock
//  reset_n      in   1              synchronous, active-low reset
//  in_valid     in   1              operand pair presented
//  in_ready     out  1              block can accept this cycle
//  in_a         in   WIDTH          multiplicand
//  in_b         in   WIDTH          multiplier
//  out_valid    out  1              product available
//  out_ready    in   1              consumer takes product this cycle
//  out_product  out  2*WIDTH        full product
//  in_flight    out  clog2(STAGES+1)  number of valid entries in the pipe
// BEHAVIOUR
//  - Reset (reset_n==0 at a clock edge): all stage valid bits, out_valid, out_product and in_flight
//    are cleared to 0 at that edge. in_ready is 1 out of reset.
//  - Reset mid-operation discards every in-flight pair; no output is produced for those pairs.
//  - Global stall: adv = !(out_valid && !out_ready). When adv==1, every stage shifts by one.
//    When adv==0, every stage holds, including the valid bit and the data.
//  - in_ready = adv (combinational from out_valid and out_ready). Accept = in_valid && in_ready.
//  - Stage 0 captures {a, b, acc=0, valid=accept} when adv==1.
//    Bubbles (valid=0) propagate normally.
//  - Stage s (0..STAGES-1) adds rows i = s*R .. s*R+R-1, with R = WIDTH/STAGES:
//    acc += b[i] ? (a_ext << i) : 0. Each row is computed in 2*WIDTH bits and truncated to 2*WIDTH.
//  - Latency: a pair accepted at edge T appears with out_valid=1 after edge T+STAGES-1,
//    i.e. STAGES edges including capture. Throughput is 1 per cycle when out_ready is held high.
//  - out_product and out_valid are registered and held stable while out_valid && !out_ready.
//  - in_flight is +1 on accept, -1 on (out_valid && out_ready), and unchanged when both or neither
//    occur. Maximum value is STAGES.
//  - Operand values never affect the handshake.
//    0 x anything, and any x 0, give 0 with normal latency.
// CONFIGURATION
//  MULT_SIGNED_EN defined: operands are two's complement.
//   - a_ext is a sign-extended to 2*WIDTH.
//   - Row i = WIDTH-1 is subtracted instead of added (acc -= b[W-1] ? a_ext<<(W-1) : 0).
//   - out_product is the signed 2*WIDTH product.
//  MULT_SIGNED_EN undefined: unsigned. a_ext is a zero-extended, and all rows are added.
// STRUCTURE
//  - Package mult_pkg holds:
//    - typedef struct mult_stage_t {valid, a, b, acc} (parameterised via localparams);
//    - the MULT_WIDTH_DEFAULT and MULT_STAGES_DEFAULT constants;
//    - function automatic row_term(a_ext, b_bit, idx, neg).
//  - Sub-module mult_stage (params WIDTH, ROWS, BASE): one register stage that adds ROWS
//    partial products starting at row BASE, and has a hold enable.
//  - mult_pipe instantiates STAGES copies of mult_stage via generate, plus the handshake
//    and in_flight logic.
// TESTING (defaults WIDTH=32, STAGES=4)
//  1. 3 x 5, out_ready=1: 15 appears exactly 4 edges after accept; in_flight goes 1 then 0.
//  2. Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE_00000001.
//     With MULT_SIGNED_EN, the same inputs (-1 x -1) -> 0x1,
//     and 0x80000000 x 0x00000002 -> 0xFFFFFFFF_00000000.
//  3. Stream 8 random pairs back-to-back with out_ready=1: 8 products in order on consecutive
//     cycles, all matching a reference model.
//  4. Backpressure: fill the pipe, then drop out_ready for 3 cycles.
//     - out_product and out_valid are held; in_ready=0; in_flight=4.
//     - On release, all results drain in order with none lost or duplicated.
//  5. Reset mid-stream: 3 pairs in flight, assert reset_n=0 for 1 cycle.
//     - out_valid=0 and in_flight=0 next cycle; the old pairs never emerge.
//     - A new pair 7 x 6 -> 42 after 4 edges.
//  6. Bubbles: alternate in_valid 1/0 with 2 x k for k = 1..5: products 2,4,6,8,10, each separated
//     by one out_valid=0 cycle.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the pipelined multiplier (mult_pipe).
//   - MULT_WIDTH_DEFAULT / MULT_STAGES_DEFAULT : default operand width and depth
//   - MULT_WIDTH_MAX / MULT_ACC_MAX            : widest operand the row helper covers
//   - mult_stage_t                             : one pipeline register at default width
//   - row_term()                               : one shifted (optionally negated) row
// Optional build macro: MULT_SIGNED_EN (two's complement operands); this package is
// identical in both builds.
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT  = 32;
  localparam int MULT_STAGES_DEFAULT = 4;

  // row_term works on a fixed wide vector so one helper serves every WIDTH; callers
  // truncate the result to their own 2*WIDTH accumulator.
  localparam int MULT_WIDTH_MAX = 64;
  localparam int MULT_ACC_MAX   = 2 * MULT_WIDTH_MAX;

  typedef struct packed {
    logic                              valid;
    logic [MULT_WIDTH_DEFAULT-1:0]     a;
    logic [MULT_WIDTH_DEFAULT-1:0]     b;
    logic [2*MULT_WIDTH_DEFAULT-1:0]   acc;
  } mult_stage_t;

  // One partial-product row: b_bit ? +/-(a_ext << idx) : 0. Arithmetic is modulo
  // 2**MULT_ACC_MAX, so the low 2*WIDTH bits are exact for any WIDTH <= MULT_WIDTH_MAX.
  function automatic logic [MULT_ACC_MAX-1:0] row_term(
    input logic [MULT_ACC_MAX-1:0] a_ext,
    input logic                    b_bit,
    input int                      idx,
    input logic                    neg
  );
    logic [MULT_ACC_MAX-1:0] shifted_s;
    shifted_s = a_ext << idx;
    if (!b_bit) begin
      row_term = {MULT_ACC_MAX{1'b0}};
    end else if (neg) begin
      row_term = {MULT_ACC_MAX{1'b0}} - shifted_s;
    end else begin
      row_term = shifted_s;
    end
  endfunction

endpackage : mult_pkg

// File: rtl/mult_if.sv
// -----------------------------------------------------------------------------
// mult_if
// Operand/product handshake bundle for mult_pipe.
//   in_valid / in_ready / in_a / in_b        : operand side
//   out_valid / out_ready / out_product      : product side
//   in_flight                                : valid entries currently in the pipe
// Modports: master = producer/consumer around the multiplier, slave = the multiplier.
// Optional build macro: MULT_SIGNED_EN (no effect on this interface).
// -----------------------------------------------------------------------------
interface mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH  = MULT_WIDTH_DEFAULT,
  parameter int STAGES = MULT_STAGES_DEFAULT
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH-1:0]               in_a;
  logic [WIDTH-1:0]               in_b;
  logic                           out_valid;
  logic                           out_ready;
  logic [2*WIDTH-1:0]             out_product;
  logic [$clog2(STAGES+1)-1:0]    in_flight;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, in_flight
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, in_flight
  );

endinterface : mult_if

// File: rtl/mult_stage.sv
// -----------------------------------------------------------------------------
// mult_stage
// One register stage of the multiplier: adds ROWS partial products, rows
// BASE .. BASE+ROWS-1, to the incoming accumulator and registers the result
// together with the operands and the valid bit.
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous active-low reset (clears the whole register)
//   hold       in   1 = keep current contents (pipeline stall)
//   stage_in   in   previous stage contents (stage_t)
//   stage_out  out  registered stage contents (stage_t)
// Optional build macro: MULT_SIGNED_EN -- sign-extends the multiplicand and
// subtracts row WIDTH-1 so the accumulated sum is the two's complement product.
// -----------------------------------------------------------------------------
module mult_stage
  import mult_pkg::*;
#(
  parameter int  WIDTH   = MULT_WIDTH_DEFAULT,
  parameter int  ROWS    = MULT_WIDTH_DEFAULT / MULT_STAGES_DEFAULT,
  parameter int  BASE    = 0,
  parameter type stage_t = mult_stage_t
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   hold,
  input  stage_t stage_in,
  output stage_t stage_out
);

  localparam int ACC_W = 2 * WIDTH;

  logic [ACC_W-1:0] a_ext_s;
  logic [ACC_W-1:0] acc_s;
  stage_t           next_s;
  stage_t           stage_r;

  // Extend the multiplicand to the accumulator width once for all rows of this stage.
  always_comb begin
`ifdef MULT_SIGNED_EN
    a_ext_s = {{WIDTH{stage_in.a[WIDTH-1]}}, stage_in.a};
`else
    a_ext_s = {{WIDTH{1'b0}}, stage_in.a};
`endif
  end

  // Sum this stage's rows into the accumulator; b bits are consumed LSB first by shifting.
  always_comb begin
    logic [ROWS-1:0] b_rows;
    logic            neg;
    acc_s  = stage_in.acc;
    b_rows = stage_in.b[BASE +: ROWS];
    neg    = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
`ifdef MULT_SIGNED_EN
      // The top multiplier bit carries negative weight in two's complement.
      neg = ((BASE + r) == (WIDTH - 1));
`else
      neg = 1'b0;
`endif
      acc_s  = acc_s + ACC_W'(row_term(MULT_ACC_MAX'(a_ext_s), b_rows[0], BASE + r, neg));
      b_rows = b_rows >> 1;
    end
  end

  // Operands and valid pass through unchanged; only the accumulator is updated.
  always_comb begin
    next_s     = stage_in;
    next_s.acc = acc_s;
  end

  // Stage register: synchronous clear, hold on stall, otherwise load.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage_r <= stage_t'({$bits(stage_t){1'b0}});
    end else if (hold) begin
      stage_r <= stage_r;
    end else begin
      stage_r <= next_s;
    end
  end

  assign stage_out = stage_r;

endmodule : mult_stage

// File: rtl/mult_pipe.sv
// -----------------------------------------------------------------------------
// mult_pipe
// Pipelined WIDTH x WIDTH -> 2*WIDTH multiplier, STAGES register stages deep,
// WIDTH/STAGES partial-product rows per stage, valid/ready on both sides.
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous active-low reset; drops every in-flight pair
//   bus        slave modport of mult_if:
//                in_valid/in_a/in_b   operands offered
//                in_ready             combinational: pipe advances this cycle
//                out_valid/out_product registered result (last stage)
//                out_ready            consumer takes the product
//                in_flight            number of valid pairs inside the pipe
// Optional build macro: MULT_SIGNED_EN -- operands and product are two's
// complement; undefined (default) gives an unsigned multiplier.
// The mult_if instance must carry the same WIDTH/STAGES as this module.
// -----------------------------------------------------------------------------
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH  = MULT_WIDTH_DEFAULT,
  parameter int STAGES = MULT_STAGES_DEFAULT
) (
  input  logic   clock,
  input  logic   reset_n,
  mult_if.slave  bus
);

  localparam int ROWS  = WIDTH / STAGES;
  localparam int CNT_W = $clog2(STAGES + 1);

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] acc;
  } stage_t;

  if ((WIDTH < 2) || (WIDTH > MULT_WIDTH_MAX) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("mult_pipe: WIDTH=%0d must be 2..%0d and divisible by STAGES=%0d",
           WIDTH, MULT_WIDTH_MAX, STAGES);
  end

  logic             adv_s;
  logic             hold_s;
  logic             accept_s;
  logic             pop_s;
  stage_t           head_s;
  stage_t           stage_q [STAGES];
  logic [CNT_W-1:0] in_flight_r;

  // One global stall: the whole pipe freezes only while a finished product waits.
  assign adv_s    = !(stage_q[STAGES-1].valid && !bus.out_ready);
  assign hold_s   = !adv_s;
  assign accept_s = bus.in_valid && adv_s;
  assign pop_s    = stage_q[STAGES-1].valid && bus.out_ready;

  // Pipe entry: a non-accepted cycle enters as a bubble so spacing is preserved.
  always_comb begin
    head_s.valid = accept_s;
    head_s.a     = bus.in_a;
    head_s.b     = bus.in_b;
    head_s.acc   = {(2*WIDTH){1'b0}};
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t in_s;

    if (s == 0) begin : g_first
      assign in_s = head_s;
    end else begin : g_next
      assign in_s = stage_q[s-1];
    end

    mult_stage #(
      .WIDTH   (WIDTH),
      .ROWS    (ROWS),
      .BASE    (s * ROWS),
      .stage_t (stage_t)
    ) u_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .hold      (hold_s),
      .stage_in  (in_s),
      .stage_out (stage_q[s])
    );
  end

  // Occupancy counter: +1 on accept, -1 on hand-off, unchanged when both or neither.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_flight_r <= {CNT_W{1'b0}};
    end else if (accept_s && !pop_s) begin
      in_flight_r <= in_flight_r + CNT_W'(1'b1);
    end else if (pop_s && !accept_s) begin
      in_flight_r <= in_flight_r - CNT_W'(1'b1);
    end else begin
      in_flight_r <= in_flight_r;
    end
  end

  assign bus.in_ready    = adv_s;
  assign bus.out_valid   = stage_q[STAGES-1].valid;
  assign bus.out_product = stage_q[STAGES-1].acc;
  assign bus.in_flight   = in_flight_r;

endmodule : mult_pipe
